// File: rtl/mio_pkg.sv
// Shared definitions for the MIO memory responder: RAMCtrl access codes,
// FSM state encoding and a small helper that classifies a RAMCtrl code.
package mio_pkg;

  // RAMCtrl access-size / sign codes driven by the CPU
  localparam logic [2:0] CTRL_WORD   = 3'b000;
  localparam logic [2:0] CTRL_HALF_S = 3'b001;
  localparam logic [2:0] CTRL_HALF_U = 3'b010;
  localparam logic [2:0] CTRL_BYTE_S = 3'b011;
  localparam logic [2:0] CTRL_BYTE_U = 3'b100;

  // Wait-state counter width; supports 0..15 wait states
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } mio_state_t;

  // True for codes 101-111, which have no defined access size
  function automatic logic ctrl_reserved(input logic [2:0] ctrl);
    return (ctrl > CTRL_BYTE_U);
  endfunction

endpackage

// File: rtl/mio_lane_align.sv
// Combinational lane steering for one bus access. Given the access code, the
// low address bits, the right-aligned store data and the current RAM word,
// it produces the byte write strobes, the merged store word, the extended
// load value and a flag for misaligned or reserved accesses. On an error the
// strobes are forced to zero so the caller can never corrupt RAM.
module mio_lane_align
  import mio_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wstrb,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        err
);

  logic [31:0] wrep;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Pick the addressed byte and half out of the RAM word (little-endian)
  always_comb begin
    rbyte = rword[7:0];
    case (addr)
      2'd0: rbyte = rword[7:0];
      2'd1: rbyte = rword[15:8];
      2'd2: rbyte = rword[23:16];
      2'd3: rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
    rhalf = addr[1] ? rword[31:16] : rword[15:0];
  end

  // Decode access size into error flag, strobes, replicated store data and load result
  always_comb begin
    err   = 1'b0;
    wstrb = 4'b0000;
    wrep  = wdata;
    rdata = 32'd0;
    case (ctrl)
      CTRL_WORD: begin
        err   = (addr != 2'b00);
        wstrb = 4'b1111;
        wrep  = wdata;
        rdata = rword;
      end
      CTRL_HALF_S, CTRL_HALF_U: begin
        err   = addr[0];
        wstrb = addr[1] ? 4'b1100 : 4'b0011;
        wrep  = {wdata[15:0], wdata[15:0]};
        rdata = (ctrl == CTRL_HALF_S) ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
      end
      CTRL_BYTE_S, CTRL_BYTE_U: begin
        err   = 1'b0;
        wstrb = 4'b0001 << addr;
        wrep  = {4{wdata[7:0]}};
        rdata = (ctrl == CTRL_BYTE_S) ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
      end
      default: begin
        err = 1'b1;
      end
    endcase
    if (err || ctrl_reserved(ctrl)) begin
      err   = 1'b1;
      wstrb = 4'b0000;
      rdata = 32'd0;
    end
  end

  // Merge the replicated store data into the old word lane by lane
  always_comb begin
    wword = rword;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) wword[8*i +: 8] = wrep[8*i +: 8];
    end
  end

endmodule

// File: rtl/mio_mem_responder.sv
// Responder end of the CPU memory/MIO bus. Takes one request at a time,
// waits a fixed number of cycles, performs a byte/half/word access on an
// internal word RAM and signals completion with a one-cycle MIO_ready pulse.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for mem_req; request fields latched when it is seen
//   ST_WAIT   | wait states; down-counter runs to zero
//   ST_ACCESS | single-cycle RAM read, store merge/write, load result capture
//   ST_DONE   | MIO_ready high for this cycle only, then back to idle
module mio_mem_responder
  import mio_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic              mem_w,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       Data_write,
  input  logic [2:0]        RAMCtrl,
  output logic [31:0]       Data_read,
  output logic              MIO_ready,
  output logic              addr_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [WAIT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

  mio_state_t         state;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [2:0]         ctrl_q;
  logic               w_q;

  logic [31:0]        ram [DEPTH];
  logic [31:0]        rword;
  logic [3:0]         lane_wstrb;
  logic [31:0]        lane_wword;
  logic [31:0]        lane_rdata;
  logic               lane_err;

  // Asynchronous word read of the latched address
  always_comb begin
    rword = ram[addr_q[ADDR_W-1:2]];
  end

  mio_lane_align u_lane (
    .ctrl  (ctrl_q),
    .addr  (addr_q[1:0]),
    .wdata (wdata_q),
    .rword (rword),
    .wstrb (lane_wstrb),
    .wword (lane_wword),
    .rdata (lane_rdata),
    .err   (lane_err)
  );

  // Transaction FSM with request latches and registered bus outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ctrl_q    <= CTRL_WORD;
      w_q       <= 1'b0;
      Data_read <= '0;
      MIO_ready <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          MIO_ready <= 1'b0;
          if (mem_req) begin
            addr_q   <= Addr;
            wdata_q  <= Data_write;
            ctrl_q   <= RAMCtrl;
            w_q      <= mem_w;
            wait_cnt <= WAIT_LOAD;
            state    <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            state <= ST_ACCESS;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_ACCESS: begin
          addr_err  <= lane_err;
          MIO_ready <= 1'b1;
          state     <= ST_DONE;
          if (lane_err) begin
            Data_read <= '0;
          end else if (!w_q) begin
            Data_read <= lane_rdata;
          end
        end
        ST_DONE: begin
          MIO_ready <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          MIO_ready <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM write on the access edge; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS && w_q && !lane_err && (lane_wstrb != 4'b0000)) begin
      ram[addr_q[ADDR_W-1:2]] <= lane_wword;
    end
  end

endmodule

// File: tb/tb_mio_mem_responder.sv
// Scoreboard bench for mio_mem_responder: one instance with two wait states
// and one with none. Expected responses come from a byte-addressed memory
// model and are queued at issue time; monitors pop and compare on MIO_ready.
module tb_mio_mem_responder;
  import mio_pkg::*;

  localparam int AW = 10;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          req, w, rdy, err;
  logic [AW-1:0] addr;
  logic [31:0]   wd, rd;
  logic [2:0]    ctrl;

  logic          req0, w0, rdy0, err0;
  logic [AW-1:0] addr0;
  logic [31:0]   wd0, rd0;
  logic [2:0]    ctrl0;

  int total = 0;
  int bad   = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  logic [7:0]  mem_m [2][1024];
  logic [31:0] last_rd [2];

  mio_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_w(w), .Addr(addr),
    .Data_write(wd), .RAMCtrl(ctrl), .Data_read(rd), .MIO_ready(rdy),
    .addr_err(err)
  );

  mio_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_req(req0), .mem_w(w0), .Addr(addr0),
    .Data_write(wd0), .RAMCtrl(ctrl0), .Data_read(rd0), .MIO_ready(rdy0),
    .addr_err(err0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: byte-level memory, little-endian, size from code, error rules
  function automatic exp_t ref_access(input int which, input logic wr, input logic [9:0] a,
                                      input logic [31:0] wdat, input logic [2:0] c);
    exp_t e;
    int n;
    logic sgn, bad_acc;
    logic [31:0] v;
    n   = (c == 3'd0) ? 4 : (c == 3'd1 || c == 3'd2) ? 2 : 1;
    sgn = (c == 3'd1 || c == 3'd3);
    bad_acc = (c > 3'd4) || (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    v = 32'd0;
    if (!bad_acc) begin
      for (int i = 0; i < n; i++) begin
        if (wr) mem_m[which][int'(a) + i] = wdat[8*i +: 8];
        else    v[8*i +: 8] = mem_m[which][int'(a) + i];
      end
      if (!wr && sgn && v[8*n-1]) begin
        for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
      end
    end
    if (bad_acc)  last_rd[which] = 32'd0;
    else if (!wr) last_rd[which] = v;
    e.rd  = last_rd[which];
    e.err = bad_acc;
    return e;
  endfunction

  task automatic drive(input int which, input logic r, input logic wr, input logic [9:0] a,
                       input logic [31:0] wdat, input logic [2:0] c);
    if (which == 0) begin
      req = r; w = wr; addr = a; wd = wdat; ctrl = c;
    end else begin
      req0 = r; w0 = wr; addr0 = a; wd0 = wdat; ctrl0 = c;
    end
  endtask

  task automatic do_txn(input int which, input logic wr, input logic [9:0] a,
                        input logic [31:0] wdat, input logic [2:0] c);
    exp_t e;
    int cnt;
    logic seen;
    e = ref_access(which, wr, a, wdat, c);
    if (which == 0) q_a.push_back(e);
    else            q_b.push_back(e);
    @(posedge clk); #1;
    drive(which, 1'b1, wr, a, wdat, c);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
      seen = (which == 0) ? rdy : rdy0;
    end
    chk(which == 0 ? "latency_w2" : "latency_w0", cnt, (which == 0) ? 4 : 2);
    drive(which, 1'b0, 1'b0, a, 32'd0, CTRL_WORD);
  endtask

  // Monitor for the two-wait-state instance
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst && rdy) begin
      if (q_a.size() == 0) begin
        chk("unexpected_ready_a", 32'd1, 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("data_read_a", rd, e.rd);
        chk("addr_err_a", {31'd0, err}, {31'd0, e.err});
      end
    end
  end

  // Monitor for the zero-wait-state instance
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst && rdy0) begin
      if (q_b.size() == 0) begin
        chk("unexpected_ready_b", 32'd1, 32'd0);
      end else begin
        e = q_b.pop_front();
        chk("data_read_b", rd0, e.rd);
        chk("addr_err_b", {31'd0, err0}, {31'd0, e.err});
      end
    end
  end

  initial begin
    int pulses, cyc, last_cyc;
    logic prev;
    exp_t e;
    drive(0, 1'b0, 1'b0, 10'd0, 32'd0, CTRL_WORD);
    drive(1, 1'b0, 1'b0, 10'd0, 32'd0, CTRL_WORD);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("reset_rd", rd, 32'd0);
    chk("reset_ready", {31'd0, rdy}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_rd0", rd0, 32'd0);

    // Fill the working region with known words
    for (int i = 0; i < 16; i++) do_txn(0, 1'b1, 10'(4*i), $urandom, CTRL_WORD);

    // Abort a store during its wait states
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 10'h010, 32'hDEADBEEF, CTRL_WORD);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_ready", {31'd0, rdy}, 32'd0);
    chk("abort_rd", rd, 32'd0);
    repeat (2) @(posedge clk);
    #1 drive(0, 1'b0, 1'b0, 10'd0, 32'd0, CTRL_WORD);
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    #2 rst = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy) pulses++;
    end
    chk("abort_no_ready", pulses, 0);
    do_txn(0, 1'b0, 10'h010, 32'd0, CTRL_WORD);

    // Directed lane cases
    do_txn(0, 1'b1, 10'h020, 32'h12345678, CTRL_WORD);
    do_txn(0, 1'b0, 10'h020, 32'd0, CTRL_WORD);
    do_txn(0, 1'b1, 10'h021, 32'h000000AB, CTRL_BYTE_S);
    do_txn(0, 1'b0, 10'h021, 32'd0, CTRL_BYTE_S);
    do_txn(0, 1'b0, 10'h021, 32'd0, CTRL_BYTE_U);
    do_txn(0, 1'b0, 10'h020, 32'd0, CTRL_WORD);
    do_txn(0, 1'b1, 10'h022, 32'h00008001, CTRL_HALF_U);
    do_txn(0, 1'b0, 10'h022, 32'd0, CTRL_HALF_S);
    do_txn(0, 1'b0, 10'h022, 32'd0, CTRL_HALF_U);
    do_txn(0, 1'b0, 10'h020, 32'd0, CTRL_WORD);
    do_txn(0, 1'b0, 10'h023, 32'd0, CTRL_WORD);
    do_txn(0, 1'b1, 10'h021, 32'h0000FFFF, CTRL_HALF_S);
    do_txn(0, 1'b1, 10'h020, 32'hFFFFFFFF, 3'b110);
    do_txn(0, 1'b0, 10'h020, 32'd0, CTRL_WORD);

    // Randomized traffic in the initialized region
    for (int i = 0; i < 60; i++) begin
      logic [2:0] c;
      c = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      do_txn(0, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 63)), $urandom, c);
    end

    // Zero-wait instance: back-to-back loads with mem_req held
    do_txn(1, 1'b1, 10'h004, 32'hC0FFEE11, CTRL_WORD);
    for (int k = 0; k < 5; k++) begin
      e = ref_access(1, 1'b0, 10'h004, 32'd0, CTRL_WORD);
      q_b.push_back(e);
    end
    @(posedge clk); #1;
    drive(1, 1'b1, 1'b0, 10'h004, 32'd0, CTRL_WORD);
    pulses = 0; cyc = 0; last_cyc = 0; prev = 1'b0;
    while (pulses < 5 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy0) begin
        chk("ready_consecutive", {31'd0, prev}, 32'd0);
        if (pulses == 0) chk("held_first_latency", cyc, 2);
        else             chk("ready_spacing", cyc - last_cyc, 3);
        pulses++;
        last_cyc = cyc;
      end
      prev = rdy0;
    end
    drive(1, 1'b0, 1'b0, 10'd0, 32'd0, CTRL_WORD);
    chk("held_pulses", pulses, 5);

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("queues_drained", q_a.size() + q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
